// File: rtl/hovalaag_link_pkg.sv
// hovalaag_link_pkg: shared widths, link states and tile pin indices for the Hovalaag host link.
package hovalaag_link_pkg;
  localparam int SLOTS = 5;
  localparam int SLOT_W = 6;
  localparam int FRAME_W = 30;
  localparam int RSP_W = 40;
  localparam int PIN_RST_EN_N = 1;
  localparam int PIN_RST = 2;
  localparam int PIN_ADDR_RST = 3;
  localparam int PIN_ROSC = 4;
  typedef enum logic [1:0] {IDLE, CHIP_RST, SYNC, STREAM} link_state_t;
  function automatic logic [7:0] ctrl_pins(input logic rst, input logic addr_rst, input logic rosc);
    logic [7:0] p;
    p = '0;
    p[PIN_RST_EN_N] = 1'b0;
    p[PIN_RST] = rst;
    p[PIN_ADDR_RST] = addr_rst;
    p[PIN_ROSC] = rosc;
    return p;
  endfunction
endpackage

// File: rtl/hovalaag_link_capture.sv
// hovalaag_link_capture: per-slot capture of tile io_out into a 40-bit response.
// Present only when HOVALAAG_LINK_RSP_EN is defined.
`ifdef HOVALAAG_LINK_RSP_EN
module hovalaag_link_capture
  import hovalaag_link_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [2:0]       slot,
  input  logic [7:0]       pin_in,
  input  logic             rsp_hold,
  output logic             rsp_valid,
  output logic [RSP_W-1:0] rsp_data,
  output logic             rsp_overrun
);
  logic [RSP_W-9:0] part;
  logic last;
  assign last = en && slot == 3'(SLOTS - 1);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      part <= '0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_overrun <= 1'b0;
    end else begin
      rsp_valid <= last;
      if (en && !last) part[8*slot +: 8] <= pin_in;
      // byte 4 goes straight into the response so it lands with the pulse
      if (last) rsp_data <= {pin_in, part};
      if (rsp_valid && rsp_hold) rsp_overrun <= 1'b1;
    end
  end
endmodule
`endif

// File: rtl/hovalaag_host_link.sv
// hovalaag_host_link: drives Hovalaag tile pins (chip reset, address sync, 5-slot frame stream).
// HOVALAAG_LINK_RSP_EN enables capture of the tile response; otherwise rsp_* are tied 0.
module hovalaag_host_link
  import hovalaag_link_pkg::*;
#(
  parameter int                 RESET_CYCLES = 4,
  parameter logic [FRAME_W-1:0] IDLE_FRAME   = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               rosc_en,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [FRAME_W-1:0] req_frame,
  output logic [7:0]         pin_out,
  input  logic [7:0]         pin_in,
  output logic               rsp_valid,
  output logic [RSP_W-1:0]   rsp_data,
  output logic               rsp_overrun,
  input  logic               rsp_hold,
  output logic               busy
);
  localparam int CW = $clog2(RESET_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(RESET_CYCLES - 1);
  link_state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] slot;
  logic [2:0] slot_nx;
  logic [FRAME_W-1:0] frame;
  logic [FRAME_W-1:0] head;
  assign head = req_valid ? req_frame : IDLE_FRAME;
  assign slot_nx = slot + 3'd1;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      slot <= '0;
      frame <= '0;
      pin_out <= 8'h02;
      req_ready <= 1'b0;
      busy <= 1'b0;
    end else begin
      req_ready <= 1'b0;
      if (start) begin
        state <= CHIP_RST;
        cnt <= '0;
        slot <= '0;
        pin_out <= ctrl_pins(1'b1, 1'b0, rosc_en);
        busy <= 1'b1;
      end else begin
        case (state)
          CHIP_RST: begin
            cnt <= cnt + 1'b1;
            state <= cnt == CNT_LAST ? SYNC : CHIP_RST;
            pin_out <= cnt == CNT_LAST ? ctrl_pins(1'b0, 1'b1, rosc_en) : ctrl_pins(1'b1, 1'b0, rosc_en);
          end
          SYNC, STREAM: begin
            // slot 0 is loaded on the edge that leaves SYNC or slot 4
            if (state == SYNC || slot == 3'(SLOTS - 1)) begin
              state <= STREAM;
              slot <= '0;
              frame <= head;
              req_ready <= req_valid;
              pin_out <= {head[SLOT_W-1:0], 2'b10};
            end else begin
              slot <= slot_nx;
              pin_out <= {frame[SLOT_W*slot_nx +: SLOT_W], 2'b10};
            end
          end
          default: ;
        endcase
      end
    end
  end
`ifdef HOVALAAG_LINK_RSP_EN
  hovalaag_link_capture u_capture (
    .clk(clk),
    .reset_n(reset_n),
    .en(state == STREAM && !start),
    .slot(slot),
    .pin_in(pin_in),
    .rsp_hold(rsp_hold),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .rsp_overrun(rsp_overrun)
  );
`else
  logic unused_rsp;
  assign unused_rsp = ^{pin_in, rsp_hold};
  assign rsp_valid = 1'b0;
  assign rsp_data = '0;
  assign rsp_overrun = 1'b0;
`endif
endmodule
